// File: rtl/test_gen_ctrl.sv
// Packet sequencer for the counter-based test-pattern generator: clears the generator,
// then streams fixed-length (or zero-length) packets into a write FIFO with optional idle gaps.
module test_gen_ctrl #(
    parameter int DW = 32,
    parameter int LW = 16,
    parameter int CW = 16,
    parameter int GW = 8
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          start,
    input  logic          stop,
    input  logic [LW-1:0] pkt_len,
    input  logic [CW-1:0] pkt_num,
    input  logic [GW-1:0] gap_len,
    output logic          gen_clr,
    output logic          gen_rd,
    input  logic [DW-1:0] gen_data,
    input  logic          fifo_full,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_data,
    output logic          pkt_end,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_DATA = 3'd2,
        S_ZLP  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_s;
    state_t        first_s;
    state_t        after_s;
    logic [LW-1:0] len_r;
    logic [LW-1:0] word_cnt_r;
    logic [CW-1:0] num_r;
    logic [CW-1:0] pkt_cnt_r;
    logic [GW-1:0] gap_r;
    logic [GW-1:0] gap_cnt_r;
    logic          stop_req_r;
    logic          wr_s;
    logic          end_s;
    logic          clr_s;
    logic          finish_s;

    // Next-state decode and combinational strobes (data path has zero added latency)
    always_comb begin
        state_s  = state_r;
        wr_s     = 1'b0;
        end_s    = 1'b0;
        clr_s    = 1'b0;
        first_s  = (len_r != {LW{1'b0}}) ? S_DATA : S_ZLP;
        finish_s = ((num_r != {CW{1'b0}}) && ((pkt_cnt_r + CW'(1)) == num_r)) || stop_req_r || stop;
        if (finish_s) begin
            after_s = S_DONE;
        end else if (gap_r != {GW{1'b0}}) begin
            after_s = S_GAP;
        end else begin
            after_s = first_s;
        end
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_CLR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR: begin
                clr_s   = 1'b1;
                state_s = first_s;
            end
            S_DATA: begin
                wr_s = ~fifo_full;
                if (wr_s && (word_cnt_r == (len_r - LW'(1)))) begin
                    end_s   = 1'b1;
                    state_s = after_s;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_ZLP: begin
                if (!fifo_full) begin
                    end_s   = 1'b1;
                    state_s = after_s;
                end else begin
                    state_s = S_ZLP;
                end
            end
            S_GAP: begin
                if (stop || stop_req_r) begin
                    state_s = S_DONE;
                end else if (gap_cnt_r == (gap_r - GW'(1))) begin
                    state_s = first_s;
                end else begin
                    state_s = S_GAP;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and run configuration latched at start
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_r    <= S_IDLE;
            len_r      <= {LW{1'b0}};
            num_r      <= {CW{1'b0}};
            gap_r      <= {GW{1'b0}};
            word_cnt_r <= {LW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            pkt_cnt_r  <= {CW{1'b0}};
            stop_req_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == S_IDLE) && start) begin
                len_r      <= pkt_len;
                num_r      <= pkt_num;
                gap_r      <= gap_len;
                word_cnt_r <= {LW{1'b0}};
                pkt_cnt_r  <= {CW{1'b0}};
                stop_req_r <= 1'b0;
            end else begin
                if (end_s) begin
                    pkt_cnt_r  <= pkt_cnt_r + CW'(1);
                    word_cnt_r <= {LW{1'b0}};
                end else if (wr_s) begin
                    word_cnt_r <= word_cnt_r + LW'(1);
                end
                if (stop && ((state_r == S_CLR) || (state_r == S_DATA) || (state_r == S_ZLP))) begin
                    stop_req_r <= 1'b1;
                end
            end
            if (state_r == S_GAP) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
        end
    end

    assign gen_clr   = clr_s;
    assign gen_rd    = wr_s;
    assign fifo_wr   = wr_s;
    assign fifo_data = gen_data;
    assign pkt_end   = end_s;
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);
    assign pkt_cnt   = pkt_cnt_r;

endmodule

// File: tb/tb_test_gen_ctrl.sv
// Bench for test_gen_ctrl: a counter generator model feeds the sequencer; runs are checked
// against a transaction-level model of the expected word stream, packet markers and timing.
module tb_test_gen_ctrl;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 16;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          reset_;
    logic          start;
    logic          start2;
    logic          stop;
    logic          fifo_full;
    logic [LW-1:0] pkt_len;
    logic [CW-1:0] pkt_num;
    logic [1:0]    pkt_num2;
    logic [GW-1:0] gap_len;
    logic          gen_clr, gen_rd, fifo_wr, pkt_end, busy, done;
    logic [DW-1:0] gen_data = '0;
    logic [DW-1:0] fifo_data;
    logic [CW-1:0] pkt_cnt;
    logic          gen_clr2, gen_rd2, fifo_wr2, pkt_end2, busy2, done2;
    logic [DW-1:0] gen_data2 = '0;
    logic [DW-1:0] fifo_data2;
    logic [1:0]    pkt_cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    test_gen_ctrl #(.DW(DW), .LW(LW), .CW(CW), .GW(GW)) dut (
        .clk(clk), .reset_(reset_), .start(start), .stop(stop),
        .pkt_len(pkt_len), .pkt_num(pkt_num), .gap_len(gap_len),
        .gen_clr(gen_clr), .gen_rd(gen_rd), .gen_data(gen_data),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .pkt_end(pkt_end), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    test_gen_ctrl #(.DW(DW), .LW(LW), .CW(2), .GW(GW)) dut2 (
        .clk(clk), .reset_(reset_), .start(start2), .stop(stop),
        .pkt_len(pkt_len), .pkt_num(pkt_num2), .gap_len(gap_len),
        .gen_clr(gen_clr2), .gen_rd(gen_rd2), .gen_data(gen_data2),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr2), .fifo_data(fifo_data2),
        .pkt_end(pkt_end2), .busy(busy2), .done(done2), .pkt_cnt(pkt_cnt2)
    );

    // Counter-based pattern generators
    always @(posedge clk) begin
        if (gen_clr) gen_data <= '0;
        else if (gen_rd) gen_data <= gen_data + 1;
        if (gen_clr2) gen_data2 <= '0;
        else if (gen_rd2) gen_data2 <= gen_data2 + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One run on dut (sel=0) or dut2 (sel=1). mode: 0 no backpressure, 1 full in cycles 3-5,
    // 2 random full. stop_w: global word index during which stop is pulsed, -1 for none.
    task automatic run_case(input bit sel, input int len, input int num, input int gap,
                            input int mode, input int stop_w, input bit poke_start);
        int exp_pk, exp_words, leff, exp_last, wr_seen, rd_seen, pk_seen, last_end, idx, k, cmod;
        bit fin, full, wr_now, o_clr, o_rd, o_wr, o_end, o_busy, o_done;
        logic [63:0] o_data, o_cnt;
        exp_pk = num;
        if (stop_w >= 0) begin
            if (num == 0 || (stop_w / len) + 1 < num) exp_pk = (stop_w / len) + 1;
        end
        exp_words = len * exp_pk;
        leff      = (len == 0) ? 1 : len;
        exp_last  = 2 + (exp_pk - 1) * (leff + gap) + leff - 1 + ((mode == 1) ? 3 : 0);
        cmod      = sel ? 4 : 65536;
        wr_seen = 0; rd_seen = 0; pk_seen = 0; last_end = 0; idx = 0; fin = 1'b0;
        @(negedge clk);
        pkt_len  = LW'(len);
        pkt_num  = CW'(num);
        pkt_num2 = 2'(num);
        gap_len  = GW'(gap);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        k = 1;
        while (k <= 4000 && !fin) begin
            case (mode)
                0: full = 1'b0;
                1: full = (k >= 3 && k <= 5);
                default: full = ($urandom_range(0, 9) < 3);
            endcase
            fifo_full = full;
            @(negedge clk);
            o_clr  = sel ? gen_clr2 : gen_clr;
            o_rd   = sel ? gen_rd2  : gen_rd;
            o_wr   = sel ? fifo_wr2 : fifo_wr;
            o_end  = sel ? pkt_end2 : pkt_end;
            o_busy = sel ? busy2    : busy;
            o_done = sel ? done2    : done;
            o_data = sel ? 64'(fifo_data2) : 64'(fifo_data);
            o_cnt  = sel ? 64'(pkt_cnt2)   : 64'(pkt_cnt);
            check_eq("gen_clr", 64'(o_clr), 64'(k == 1));
            check_eq("busy", 64'(o_busy), 64'd1);
            check_eq("pkt_cnt", o_cnt, 64'(pk_seen % cmod));
            check_eq("wr_while_full", 64'(o_wr && full), 64'd0);
            if (len == 0) check_eq("zlp_wr", 64'(o_wr), 64'd0);
            wr_now = o_wr;
            if (o_wr) begin
                idx = wr_seen;
                check_eq("fifo_data", o_data, 64'(idx));
                if (mode != 2)
                    check_eq("word_cyc", 64'(k),
                             64'(2 + idx + (idx / len) * gap + ((mode == 1 && idx >= 1) ? 3 : 0)));
                wr_seen++;
            end
            if (o_rd) rd_seen++;
            if (len > 0)
                check_eq("pkt_end", 64'(o_end), 64'(o_wr && (idx % len == len - 1)));
            else if (mode == 0)
                check_eq("zlp_end", 64'(o_end), 64'(k >= 2 && (k - 2) % (1 + gap) == 0 && pk_seen < exp_pk));
            else
                check_eq("zlp_full", 64'(o_end && full), 64'd0);
            if (o_end) begin
                pk_seen++;
                last_end = k;
            end
            if (o_done) begin
                check_eq("done_pkts", 64'(pk_seen), 64'(exp_pk));
                check_eq("done_words", 64'(wr_seen), 64'(exp_words));
                check_eq("done_reads", 64'(rd_seen), 64'(exp_words));
                check_eq("done_after_end", 64'(k), 64'(last_end + 1));
                if (mode != 2) check_eq("done_cyc", 64'(k), 64'(exp_last + 1));
                fin = 1'b1;
            end
            stop = (stop_w >= 0) && wr_now && (idx == stop_w);
            if (poke_start && (k % 5 == 3)) start = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0; start = 1'b0;
            k++;
        end
        fifo_full = 1'b0;
        if (!fin) begin
            check_eq("timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            check_eq("busy_after", 64'(sel ? busy2 : busy), 64'd0);
            check_eq("done_after", 64'(sel ? done2 : done), 64'd0);
        end
    endtask

    initial begin
        int len, num, gap, mode, stop_w;
        reset_ = 1'b0; start = 1'b0; start2 = 1'b0; stop = 1'b0; fifo_full = 1'b0;
        pkt_len = '0; pkt_num = '0; pkt_num2 = '0; gap_len = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {58'd0, gen_clr, gen_rd, fifo_wr, pkt_end, busy, done}, 64'd0);
        check_eq("rst_cnt", 64'(pkt_cnt), 64'd0);
        reset_ = 1'b1;
        @(negedge clk);

        run_case(1'b0, 4, 3, 2, 0, -1, 1'b0);
        run_case(1'b0, 4, 3, 2, 1, -1, 1'b0);
        run_case(1'b0, 0, 2, 0, 0, -1, 1'b0);
        run_case(1'b0, 8, 0, 0, 0, 10, 1'b1);

        // Reset during the second packet of a 5-packet run
        @(negedge clk);
        pkt_len = 16'd4; pkt_num = 16'd5; gap_len = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'd1);
        reset_ = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_outs", {58'd0, gen_clr, gen_rd, fifo_wr, pkt_end, busy, done}, 64'd0);
        check_eq("mid_rst_cnt", 64'(pkt_cnt), 64'd0);
        reset_ = 1'b1;
        run_case(1'b0, 4, 2, 1, 0, -1, 1'b0);

        run_case(1'b1, 1, 0, 0, 0, 5, 1'b0);

        for (int r = 0; r < 14; r++) begin
            len    = $urandom_range(0, 9);
            num    = $urandom_range(1, 5);
            gap    = $urandom_range(0, 4);
            mode   = ($urandom_range(0, 1) == 0) ? 0 : 2;
            stop_w = -1;
            if (len > 0 && $urandom_range(0, 2) == 0) begin
                stop_w = $urandom_range(0, len * num - 1);
                if ($urandom_range(0, 1) == 0) num = 0;
            end
            run_case(1'b0, len, num, gap, mode, stop_w, r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
